// File: rtl/and_gate_pkg.sv
// and_gate_pkg: shared constants and the pipeline stage record for and_gate.
//   CNT_W / CNT_MAX : width and saturation value of the all-ones result counter
//   MAX_STAGES      : deepest supported pipeline
//   MAX_WIDTH       : widest supported operand
//   stage_t         : {valid, data} record carried by every pipeline stage
package and_gate_pkg;

    localparam int              CNT_W      = 16;
    localparam logic [CNT_W-1:0] CNT_MAX   = 16'hFFFF;
    localparam int              MAX_STAGES = 4;
    localparam int              MAX_WIDTH  = 64;

    // Data is sized for the widest operand; bits above WIDTH are held at 0.
    typedef struct packed {
        logic                 valid;
        logic [MAX_WIDTH-1:0] data;
    } stage_t;

endpackage

// File: rtl/and_gate_if.sv
// and_gate_if: operand/result bundle for and_gate.
//   i_valid, i_1, i_2 : operands and their qualifier (driven by master)
//   o, o_valid        : registered result and its qualifier (driven by slave)
//   o_ones_cnt        : all-ones result counter, present only when the
//                       AND_GATE_CNT_EN macro is defined
interface and_gate_if
    import and_gate_pkg::*;
#(
    parameter int WIDTH = 1
) ();

    logic             i_valid;
    logic [WIDTH-1:0] i_1;
    logic [WIDTH-1:0] i_2;
    logic [WIDTH-1:0] o;
    logic             o_valid;
`ifdef AND_GATE_CNT_EN
    logic [CNT_W-1:0] o_ones_cnt;
`endif

    modport master (
        output i_valid, i_1, i_2,
`ifdef AND_GATE_CNT_EN
        input  o_ones_cnt,
`endif
        input  o, o_valid
    );

    modport slave (
        input  i_valid, i_1, i_2,
`ifdef AND_GATE_CNT_EN
        output o_ones_cnt,
`endif
        output o, o_valid
    );

endinterface

// File: rtl/and_gate_stage.sv
// and_gate_stage: one pipeline register for the {valid, data} record.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, clears valid and data
//   stage_d : record to capture
//   stage_q : registered record
module and_gate_stage
    import and_gate_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  stage_t stage_d,
    output stage_t stage_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

endmodule

// File: rtl/and_gate.sv
// and_gate: registered bitwise AND with a valid strobe and fixed latency.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, flushes every stage
//   bus : and_gate_if slave (i_valid, i_1, i_2 in; o, o_valid out;
//         o_ones_cnt out when AND_GATE_CNT_EN is defined)
// Parameters: WIDTH (1..64) operand width, STAGES (1..4) latency in edges.
// Macro AND_GATE_CNT_EN adds a 16-bit saturating count of valid all-ones
// results; without it only the data pipeline is built.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic       clk,
    input  logic       rst,
    and_gate_if.slave  bus
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("and_gate: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("and_gate: STAGES=%0d outside 1..%0d", STAGES, MAX_STAGES);
    end

    stage_t stage0_d;
    stage_t pipe_d [STAGES];
    stage_t pipe_q [STAGES];

    // Stage 0 input: the AND itself; data loads whether or not i_valid is set.
    always_comb begin
        stage0_d                = '0;
        stage0_d.valid          = bus.i_valid;
        stage0_d.data[WIDTH-1:0] = bus.i_1 & bus.i_2;
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign pipe_d[i] = stage0_d;
        end else begin : g_next
            assign pipe_d[i] = pipe_q[i-1];
        end

        and_gate_stage u_stage (
            .clk     (clk),
            .rst     (rst),
            .stage_d (pipe_d[i]),
            .stage_q (pipe_q[i])
        );
    end

    // Last stage boundary: registered outputs.
    assign bus.o       = pipe_q[STAGES-1].data[WIDTH-1:0];
    assign bus.o_valid = pipe_q[STAGES-1].valid;

    // Padding bits above WIDTH are constant 0 and intentionally not output.
    logic unused_hi;
    assign unused_hi = ^pipe_q[STAGES-1].data;

`ifdef AND_GATE_CNT_EN
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Look at the record entering the last stage so the count moves on the
    // same edge that presents the all-ones result.
    always_comb begin
        cnt_d = cnt_q;
        if (pipe_d[STAGES-1].valid && (&pipe_d[STAGES-1].data[WIDTH-1:0])) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.o_ones_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: three and_gate instances (1b/1 stage, 8b/3 stages,
// 8b/4 stages) checked against a history-indexed reference model plus
// directed expectations. Counter checks are compiled with AND_GATE_CNT_EN.
module tb_and_gate;

    logic clk = 1'b0;
    logic rst;
    logic mon_en;

    always #5 clk = ~clk;

    and_gate_if #(.WIDTH(1)) if1 ();
    and_gate_if #(.WIDTH(8)) if8 ();
    and_gate_if #(.WIDTH(8)) if4 ();

    and_gate #(.WIDTH(1), .STAGES(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1));
    and_gate #(.WIDTH(8), .STAGES(3)) u_d8 (.clk(clk), .rst(rst), .bus(if8));
    and_gate #(.WIDTH(8), .STAGES(4)) u_d4 (.clk(clk), .rst(rst), .bus(if4));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: every sampled operand pair is logged by edge number;
    // the result visible after edge n is the pair sampled STAGES edges
    // earlier, or zero if that sample predates the latest reset.
    logic [8:0] samp [3][16];
    int         ncyc     = 0;
    int         rst_mark = 0;
    logic       exp_v [3];
    logic [7:0] exp_d [3];
    int         cnt_m [3];
    int         stg [3]   = '{1, 3, 4};
    logic [7:0] msk [3]   = '{8'h01, 8'hFF, 8'hFF};

    always @(posedge clk or posedge rst) begin
        int idx;
        if (rst) begin
            rst_mark = ncyc;
            for (int k = 0; k < 3; k++) begin
                exp_v[k] = 1'b0;
                exp_d[k] = 8'h00;
                cnt_m[k] = 0;
            end
        end else begin
            samp[0][ncyc % 16] = {if1.i_valid, 7'd0, if1.i_1 & if1.i_2};
            samp[1][ncyc % 16] = {if8.i_valid, if8.i_1 & if8.i_2};
            samp[2][ncyc % 16] = {if4.i_valid, if4.i_1 & if4.i_2};
            ncyc++;
            for (int k = 0; k < 3; k++) begin
                idx = ncyc - stg[k];
                if (idx >= rst_mark) begin
                    exp_v[k] = samp[k][idx % 16][8];
                    exp_d[k] = samp[k][idx % 16][7:0];
                end else begin
                    exp_v[k] = 1'b0;
                    exp_d[k] = 8'h00;
                end
                if (exp_v[k] && exp_d[k] == msk[k] && cnt_m[k] < 65535) cnt_m[k]++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (mon_en && !rst) begin
            check_val("mon_d1_o",  64'(if1.o),       64'(exp_d[0]));
            check_val("mon_d1_v",  64'(if1.o_valid), 64'(exp_v[0]));
            check_val("mon_d8_o",  64'(if8.o),       64'(exp_d[1]));
            check_val("mon_d8_v",  64'(if8.o_valid), 64'(exp_v[1]));
            check_val("mon_d4_o",  64'(if4.o),       64'(exp_d[2]));
            check_val("mon_d4_v",  64'(if4.o_valid), 64'(exp_v[2]));
`ifdef AND_GATE_CNT_EN
            check_val("mon_d1_cnt", 64'(if1.o_ones_cnt), 64'(cnt_m[0]));
            check_val("mon_d8_cnt", 64'(if8.o_ones_cnt), 64'(cnt_m[1]));
            check_val("mon_d4_cnt", 64'(if4.o_ones_cnt), 64'(cnt_m[2]));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if1.i_valid = 1'b0; if1.i_1 = 1'b0;  if1.i_2 = 1'b0;
        if8.i_valid = 1'b0; if8.i_1 = 8'h00; if8.i_2 = 8'h00;
        if4.i_valid = 1'b0; if4.i_1 = 8'h00; if4.i_2 = 8'h00;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic tt_a [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic tt_b [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic tt_e [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst    = 1'b0;
        mon_en = 1'b0;
        idle_all();
        #1 rst = 1'b1;
        #1;
        check_val("rst_d1_o", 64'(if1.o),       64'h0);
        check_val("rst_d1_v", 64'(if1.o_valid), 64'h0);
        check_val("rst_d8_o", 64'(if8.o),       64'h0);
        check_val("rst_d4_v", 64'(if4.o_valid), 64'h0);
`ifdef AND_GATE_CNT_EN
        check_val("rst_d1_cnt", 64'(if1.o_ones_cnt), 64'h0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Truth table on the 1-bit gate.
        for (int i = 0; i < 5; i++) begin
            if1.i_valid = 1'b1;
            if1.i_1     = tt_a[i];
            if1.i_2     = tt_b[i];
            step();
            check_val("tt_o", 64'(if1.o),       64'(tt_e[i]));
            check_val("tt_v", 64'(if1.o_valid), 64'h1);
        end

        // Asynchronous reset while o=1, then release with (1,1) applied.
        #2 rst = 1'b1;
        #1;
        check_val("arst_o", 64'(if1.o),       64'h0);
        check_val("arst_v", 64'(if1.o_valid), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_val("rel_o", 64'(if1.o),       64'h1);
        check_val("rel_v", 64'(if1.o_valid), 64'h1);

        // Four more valid all-ones results: five since the reset.
        repeat (4) step();
`ifdef AND_GATE_CNT_EN
        check_val("cnt_five", 64'(if1.o_ones_cnt), 64'd5);
`endif

        // Valid gating: data still flows, valid and counter do not.
        if1.i_valid = 1'b0;
        step();
        check_val("gate_o", 64'(if1.o),       64'h1);
        check_val("gate_v", 64'(if1.o_valid), 64'h0);
`ifdef AND_GATE_CNT_EN
        check_val("gate_cnt", 64'(if1.o_ones_cnt), 64'd5);
`endif

        // Three-stage pipeline on the 8-bit gate.
        idle_all();
        if8.i_valid = 1'b1; if8.i_1 = 8'hF0; if8.i_2 = 8'h3C;
        step();
        if8.i_1 = 8'hFF; if8.i_2 = 8'hAA;
        step();
        check_val("pipe_e2_v", 64'(if8.o_valid), 64'h0);
        idle_all();
        step();
        check_val("pipe_e3_o", 64'(if8.o),       64'h30);
        check_val("pipe_e3_v", 64'(if8.o_valid), 64'h1);
        step();
        check_val("pipe_e4_o", 64'(if8.o),       64'hAA);
        check_val("pipe_e4_v", 64'(if8.o_valid), 64'h1);
        step();
        check_val("pipe_e5_o", 64'(if8.o),       64'h00);
        check_val("pipe_e5_v", 64'(if8.o_valid), 64'h0);

        // Four-stage pipeline: reset with three valid results in flight.
        if4.i_valid = 1'b1; if4.i_1 = 8'hFF; if4.i_2 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("mid_fill_v", 64'(if4.o_valid), 64'h0);
        end
        idle_all();
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_v", 64'(if4.o_valid), 64'h0);
`ifdef AND_GATE_CNT_EN
        check_val("mid_rst_cnt", 64'(if1.o_ones_cnt), 64'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("mid_flush_v", 64'(if4.o_valid), 64'h0);
            check_val("mid_flush_o", 64'(if4.o),       64'h0);
        end
`ifdef AND_GATE_CNT_EN
        check_val("mid_cnt", 64'(if4.o_ones_cnt), 64'h0);
`endif

        // Randomized traffic on all three instances, checked by the monitor.
        for (int c = 0; c < 400; c++) begin
            if1.i_valid = 1'($urandom_range(0, 1));
            if1.i_1     = ($urandom_range(0, 3) != 0);
            if1.i_2     = ($urandom_range(0, 3) != 0);
            if8.i_valid = 1'($urandom_range(0, 1));
            if8.i_1     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            if8.i_2     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            if4.i_valid = 1'($urandom_range(0, 1));
            if4.i_1     = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            if4.i_2     = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            step();
        end

`ifdef AND_GATE_CNT_EN
        // Saturation: more all-ones results than the counter can hold.
        idle_all();
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if1.i_valid = 1'b1; if1.i_1 = 1'b1; if1.i_2 = 1'b1;
        repeat (65540) step();
        check_val("sat_cnt", 64'(if1.o_ones_cnt), 64'hFFFF);
        step();
        check_val("sat_hold", 64'(if1.o_ones_cnt), 64'hFFFF);
`endif

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
